multicycle_ctrl: RTL and testbench

Sequencing FSM for the multi-cycle RV32I core: owns the PC and instruction register, drives instruction-memory and data-memory request/response handshakes, and times register-file writeback from the decoder's control outputs. Sits between the memories and the decode/ALU datapath. It issues one instruction at a time, with no overlap. It also counts retired instructions and halts in a sticky trap on an illegal instruction or a misaligned control-transfer target.

---
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I core.
// Issues one instruction at a time, owns pc/instr, times writeback and halts in a sticky trap.
module multicycle_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        reg_write,
   input  logic        illegal,
   input  logic        branch_taken,
   input  logic [31:0] target_addr,
   output logic [31:0] pc,
   output logic        rf_we,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   input  logic        dmem_rsp_valid,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, TRAP
   } state_e;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [1:0]  CAUSE_ILL = 2'd1;
   localparam logic [1:0]  CAUSE_MIS = 2'd2;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] next_pc_q, next_pc_d;
   logic [31:0] instret_q, instret_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] exec_pc;
   logic        retire;

   // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in always_comb.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH_REQ;
         pc_q      <= RESET_PC;
         instr_q   <= NOP;
         next_pc_q <= RESET_PC;
         instret_q <= '0;
         cause_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         next_pc_q <= next_pc_d;
         instret_q <= instret_d;
         cause_q   <= cause_d;
      end
   end

   always_comb begin
      if (is_jal || (is_branch && branch_taken)) exec_pc = target_addr;
      else if (is_jalr)                          exec_pc = target_addr & ~32'h1;
      else                                       exec_pc = pc_q + 32'd4;
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      next_pc_d = next_pc_q;
      cause_d   = cause_q;
      retire    = 1'b0;
      unique case (state_q)
         FETCH_REQ:  if (imem_req_ready) state_d = FETCH_WAIT;
         FETCH_WAIT: if (imem_rsp_valid) begin
            instr_d = imem_rsp_data;
            state_d = DECODE;
         end
         DECODE: begin
            if (illegal) begin
               state_d = TRAP;
               cause_d = CAUSE_ILL;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            next_pc_d = exec_pc;
            if (exec_pc[1:0] != 2'b00) begin
               state_d = TRAP;
               cause_d = CAUSE_MIS;
            end else if (is_load || is_store) begin
               state_d = MEM_REQ;
            end else begin
               state_d = WB;
            end
         end
         MEM_REQ:  if (dmem_req_ready) state_d = MEM_WAIT;
         MEM_WAIT: if (dmem_rsp_valid) begin
            if (is_store) begin
               retire  = 1'b1;
               state_d = FETCH_REQ;
            end else begin
               state_d = WB;
            end
         end
         WB: begin
            retire  = 1'b1;
            state_d = FETCH_REQ;
         end
         TRAP:    state_d = TRAP;
         default: state_d = FETCH_REQ;
      endcase
      pc_d      = retire ? next_pc_q : pc_q;
      instret_d = retire ? instret_q + 32'd1 : instret_q;
   end

   // Request valid is masked while reset is asserted, since FETCH_REQ is the reset state.
   always_comb begin
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      dmem_we        = 1'b0;
      rf_we          = 1'b0;
      trap           = 1'b0;
      unique case (state_q)
         FETCH_REQ: imem_req_valid = rst_n;
         MEM_REQ: begin
            dmem_req_valid = 1'b1;
            dmem_we        = is_store;
         end
         WB:      rf_we = reg_write;
         TRAP:    trap  = 1'b1;
         default: ;
      endcase
   end

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign instr      = instr_q;
   assign instret    = instret_q;
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: the bench plays memories and decoder, and checks
// cycle counts, pc/instret updates, handshakes and trap behaviour against hand-computed values.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [31:0] instr;
   logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jal = 1'b0;
   logic        is_jalr = 1'b0, reg_write = 1'b0, illegal = 1'b0, branch_taken = 1'b0;
   logic [31:0] target_addr = '0;
   logic [31:0] pc;
   logic        rf_we;
   logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_we, dmem_rsp_valid = 1'b0;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr(instr),
      .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jal(is_jal),
      .is_jalr(is_jalr), .reg_write(reg_write), .illegal(illegal),
      .branch_taken(branch_taken), .target_addr(target_addr),
      .pc(pc), .rf_we(rf_we),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_rsp_valid(dmem_rsp_valid),
      .trap(trap), .trap_cause(trap_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   // Decoder flag vectors: {illegal, reg_write, is_jalr, is_jal, is_branch, is_store, is_load}
   localparam logic [6:0] F_ALU  = 7'b0100000;
   localparam logic [6:0] F_JAL  = 7'b0101000;
   localparam logic [6:0] F_JALR = 7'b0110000;
   localparam logic [6:0] F_BR   = 7'b0000100;
   localparam logic [6:0] F_LD   = 7'b0100001;
   localparam logic [6:0] F_ST   = 7'b0000010;
   localparam logic [6:0] F_ILL  = 7'b1000000;

   int n_checks = 0;
   int n_errors = 0;
   int cycles, rf_pulses, dreq_cycles, we_bad;
   logic [31:0] fetch_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Asserts reset mid-cycle (exercising the async path), checks held values, releases on a negedge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_pc"}, pc, 32'h0);
      check({tag, "_instr"}, instr, 32'h0000_0013);
      check({tag, "_instret"}, instret, 32'h0);
      check({tag, "_outs"}, {imem_req_valid, dmem_req_valid, dmem_we, rf_we, trap, trap_cause}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check({tag, "_req_after"}, imem_req_valid, 1'b1);
   endtask

   // Runs one instruction until it retires or traps; inputs change only on the falling edge.
   task automatic run_instr(input string tag, input logic [31:0] word, input logic [6:0] f,
                            input logic taken, input logic [31:0] tgt,
                            input int ireq_dly, input int irsp_dly,
                            input int dreq_dly, input int drsp_dly);
      logic [31:0] start_ret;
      int  iw, il, dw, dl;
      bit  ipend, iacc, dpend, dacc, done;
      start_ret = instret;
      iw = 0; il = 0; dw = 0; dl = 0;
      ipend = 0; iacc = 0; dpend = 0; dacc = 0; done = 0;
      {illegal, reg_write, is_jalr, is_jal, is_branch, is_store, is_load} = f;
      branch_taken = taken;
      target_addr  = tgt;
      cycles = 0; rf_pulses = 0; dreq_cycles = 0; we_bad = 0;
      while (cycles < 60 && !done) begin
         if (ipend) begin iacc = 1; ipend = 0; end
         if (dpend) begin dacc = 1; dpend = 0; end
         imem_req_ready = 0; imem_rsp_valid = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
         if (imem_req_valid) begin
            if (iw == ireq_dly) begin
               imem_req_ready = 1; ipend = 1; fetch_addr = imem_addr;
            end else iw++;
         end
         if (iacc) begin
            if (il == irsp_dly) begin
               imem_rsp_valid = 1; imem_rsp_data = word; iacc = 0;
            end else il++;
         end
         if (dmem_req_valid) begin
            dreq_cycles++;
            if (dmem_we !== f[1]) we_bad++;
            if (dw == dreq_dly) begin
               dmem_req_ready = 1; dpend = 1;
            end else dw++;
         end
         if (dacc) begin
            if (dl == drsp_dly) begin
               dmem_rsp_valid = 1; dacc = 0;
            end else dl++;
         end
         if (rf_we) rf_pulses++;
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (instret !== start_ret || trap) done = 1;
      end
      check({tag, "_done"}, done, 1'b1);
      imem_req_ready = 0; imem_rsp_valid = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
      {illegal, reg_write, is_jalr, is_jal, is_branch, is_store, is_load} = '0;
      #1;
   endtask

   initial begin
      int bad;
      do_reset("rst0");

      run_instr("addi", 32'h0050_0093, F_ALU, 0, 32'h0, 0, 0, 0, 0);
      check("addi_cycles", cycles, 5);
      check("addi_rf", rf_pulses, 1);
      check("addi_pc", pc, 32'h4);
      check("addi_instret", instret, 1);
      check("addi_instr", instr, 32'h0050_0093);
      check("addi_fetch_addr", fetch_addr, 32'h0);

      run_instr("jal", 32'h0080_006F, F_JAL, 0, 32'h10, 0, 0, 0, 0);
      check("jal_pc", pc, 32'h10);
      check("jal_rf", rf_pulses, 1);

      run_instr("bnt", 32'h0000_1863, F_BR, 0, 32'h80, 0, 0, 0, 0);
      check("bnt_cycles", cycles, 5);
      check("bnt_pc", pc, 32'h14);
      check("bnt_rf", rf_pulses, 0);

      run_instr("jal2", 32'hFFDF_F06F, F_JAL, 0, 32'h10, 0, 0, 0, 0);
      check("jal2_pc", pc, 32'h10);

      run_instr("beq", 32'h0200_0863, F_BR, 1, 32'h40, 0, 0, 0, 0);
      check("beq_pc", pc, 32'h40);
      check("beq_rf", rf_pulses, 0);
      check("beq_instret", instret, 5);

      run_instr("lw", 32'h0001_2103, F_LD, 0, 32'h0, 0, 0, 3, 1);
      check("lw_cycles", cycles, 11);
      check("lw_dreq_held", dreq_cycles, 4);
      check("lw_we", we_bad, 0);
      check("lw_rf", rf_pulses, 1);
      check("lw_pc", pc, 32'h44);

      run_instr("sw", 32'h0011_2023, F_ST, 0, 32'h0, 0, 0, 0, 0);
      check("sw_cycles", cycles, 6);
      check("sw_we", we_bad, 0);
      check("sw_dreq", dreq_cycles, 1);
      check("sw_rf", rf_pulses, 0);
      check("sw_pc", pc, 32'h48);
      check("sw_instret", instret, 7);

      run_instr("jalr", 32'h0000_8067, F_JALR, 0, 32'h21, 0, 0, 0, 0);
      check("jalr_pc", pc, 32'h20);

      run_instr("slowfetch", 32'h0050_0093, F_ALU, 0, 32'h0, 2, 1, 0, 0);
      check("slowfetch_cycles", cycles, 8);
      check("slowfetch_addr", fetch_addr, 32'h20);
      check("slowfetch_pc", pc, 32'h24);

      run_instr("jalhi", 32'h0000_006F, F_JAL, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);
      check("jalhi_pc", pc, 32'hFFFF_FFFC);
      run_instr("nopwrap", 32'h0000_0013, F_ALU, 0, 32'h0, 0, 0, 0, 0);
      check("nopwrap_pc", pc, 32'h0);
      check("nopwrap_instret", instret, 11);

      run_instr("jalr_mis", 32'h0000_8067, F_JALR, 0, 32'h0000_0103, 0, 0, 0, 0);
      check("jalr_mis_cycles", cycles, 4);
      check("jalr_mis_trap", trap, 1);
      check("jalr_mis_cause", trap_cause, 2);
      check("jalr_mis_pc", pc, 32'h0);
      check("jalr_mis_instret", instret, 11);
      // Stray responses and readies while trapped must change nothing.
      bad = 0;
      imem_rsp_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 6; i++) begin
         imem_req_ready = 1; imem_rsp_valid = 1; dmem_req_ready = 1; dmem_rsp_valid = 1;
         if (imem_req_valid || dmem_req_valid || rf_we || !trap) bad++;
         @(negedge clk);
      end
      imem_req_ready = 0; imem_rsp_valid = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
      check("trap_quiet", bad, 0);
      check("trap_instr_frozen", instr, 32'h0000_8067);
      check("trap_pc_frozen", pc, 32'h0);

      do_reset("rst1");
      check("rst1_trap", trap, 0);

      run_instr("ill", 32'hFFFF_FFFF, F_ILL, 0, 32'h0, 0, 0, 0, 0);
      check("ill_cycles", cycles, 3);
      check("ill_trap", trap, 1);
      check("ill_cause", trap_cause, 1);
      check("ill_instr", instr, 32'hFFFF_FFFF);
      check("ill_instret", instret, 0);

      do_reset("rst2");
      check("rst2_trap", trap, 0);
      check("rst2_cause", trap_cause, 0);

      run_instr("recover", 32'h0050_0093, F_ALU, 0, 32'h0, 0, 0, 0, 0);
      check("recover_pc", pc, 32'h4);
      check("recover_instret", instret, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
